// File: rtl/mix_columns_seq.sv
// Column-serial AES-128 forward MixColumns: one 32-bit column per clock through a
// single GF(2^8) column multiplier, with a pass-through path for the final round.
module mix_columns_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         final_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned ColW   = 32;
  localparam int unsigned StateW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          col_cnt_q, col_cnt_d;
  logic [StateW-1:0]   in_q, in_d;
  logic [StateW-1:0]   out_q, out_d;
  logic [ColW-1:0]     col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Input column select feeding the single shared multiplier.
  always_comb begin
    col_in = in_q[127:96];
    unique case (col_cnt_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = in_q[127:96];
    endcase
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    col_out = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
               a0 ^ d1 ^ d2 ^ a2 ^ a3,
               a0 ^ a1 ^ d2 ^ d3 ^ a3,
               d0 ^ a0 ^ a1 ^ a2 ^ d3};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      in_q      <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      in_q      <= in_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    in_d      = in_q;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d      = in_state;
          col_cnt_d = 2'd0;
          if (final_round) begin
            out_d   = in_state;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        unique case (col_cnt_q)
          2'd0: out_d[127:96] = col_out;
          2'd1: out_d[95:64]  = col_out;
          2'd2: out_d[63:32]  = col_out;
          2'd3: out_d[31:0]   = col_out;
          default: out_d[127:96] = col_out;
        endcase
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and randomised checks of mix_columns_seq against FIPS-197 vectors and
// an independent matrix-form GF(2^8) model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         final_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FipsIn  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FipsOut = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KcIn    = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] KcOut   = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] BypIn   = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_columns_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .final_round (final_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(base[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Accept one block with out_ready=1 and check exact latency and result.
  task automatic do_block(input string tag, input logic [127:0] st, input logic fr,
                          input logic [127:0] exp);
    in_state    = st;
    final_round = fr;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    if (fr) begin
      check({tag, "_byp_valid"}, 128'(out_valid), 128'd1);
    end else begin
      check({tag, "_busy_ready"}, 128'(in_ready), 128'd0);
      for (int i = 0; i < 3; i++) begin
        check({tag, "_busy_valid"}, 128'(out_valid), 128'd0);
        tick();
      end
      check({tag, "_pre_valid"}, 128'(out_valid), 128'd0);
      tick();
      check({tag, "_valid"}, 128'(out_valid), 128'd1);
    end
    check({tag, "_data"}, out_state, exp);
    tick();
    check({tag, "_post_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_post_ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] hold;
    logic [127:0] st;
    logic [127:0] exp;
    logic [127:0] cap;
    logic         fr;
    logic         got;
    int           guard;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_state    = '0;
    final_round = 1'b0;
    out_ready   = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_state", out_state, 128'h0);

    do_block("fips", FipsIn, 1'b0, FipsOut);
    do_block("known", KcIn, 1'b0, KcOut);
    do_block("bypass", BypIn, 1'b1, BypIn);
    check("model_fips", mix_model(FipsIn), FipsOut);

    // Backpressure: result held, no accept while DONE.
    out_ready   = 1'b0;
    in_state    = FipsIn;
    final_round = 1'b0;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      tick();
      guard++;
    end
    hold = out_state;
    check("bp_data", hold, FipsOut);
    for (int i = 0; i < 10; i++) begin
      in_valid    = i[0];
      in_state    = {$urandom, $urandom, $urandom, $urandom};
      final_round = 1'($urandom_range(0, 1));
      tick();
      check("bp_stable", out_state, hold);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid    = 1'b1;
    in_state    = KcIn;
    final_round = 1'b0;
    out_ready   = 1'b1;
    tick();
    check("bp_hs_valid", 128'(out_valid), 128'd0);
    check("bp_hs_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second_accept", 128'(in_ready), 128'd0);
    tick(); tick(); tick();
    check("bp_second_pre", 128'(out_valid), 128'd0);
    tick();
    check("bp_second_valid", 128'(out_valid), 128'd1);
    check("bp_second_data", out_state, KcOut);
    tick();

    // Asynchronous reset while BUSY.
    in_state    = FipsIn;
    final_round = 1'b0;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_state", out_state, 128'h0);
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    tick();
    reset = 1'b0;
    tick();
    check("after_rst_ready", 128'(in_ready), 128'd1);
    do_block("after_rst", KcIn, 1'b0, KcOut);

    // Random blocks with random stalls, compared in order against the model.
    for (int n = 0; n < 1000; n++) begin
      in_valid = 1'b0;
      for (int d = $urandom_range(0, 2); d > 0; d--) tick();
      st = {$urandom, $urandom, $urandom, $urandom};
      fr = 1'($urandom_range(0, 1));
      exp = fr ? st : mix_model(st);
      in_state    = st;
      final_round = fr;
      in_valid    = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      tick();
      in_valid = 1'b0;
      got   = 1'b0;
      cap   = '0;
      guard = 0;
      while (!got && guard < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          got = 1'b1;
          cap = out_state;
        end
        tick();
        guard++;
      end
      n_cmp++;
      assert (got) else begin
        n_err++;
        $error("FAIL rand_timeout: block %0d observed no output, expected one", n);
      end
      check("rand_data", cap, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
